// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame: LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum byte.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs accepted bytes little-endian into 32-bit words.
// o_word/o_word_valid are combinational on the fourth byte so the caller can register them.
module loader_word_assembler
    import imem_boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    logic [1:0]  r_idx;
    logic [23:0] r_pack;

    assign o_word_valid = i_en && (r_idx == 2'd3);
    assign o_word       = {i_byte, r_pack};

    // Right shift: after three bytes r_pack holds {b2, b1, b0}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= 2'd0;
            r_pack <= 24'd0;
        end else if (i_clr) begin
            r_idx  <= 2'd0;
            r_pack <= 24'd0;
        end else if (i_en) begin
            r_idx  <= r_idx + 2'd1;
            r_pack <= {i_byte, r_pack[23:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed byte stream, writes words into instruction memory,
// and releases the core from reset only after a frame with a matching checksum.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e              r_state, w_state_nxt;
    logic [LEN_W-1:0]    r_len, w_len_nxt, w_len_full;
    logic [BYTE_W-1:0]   r_csum, w_csum_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt, w_tmo_inc;
    logic [ADDR_W:0]     r_words, w_words_nxt, w_words_inc;
    logic [1:0]          r_err_code, w_err_code_nxt;
    logic                r_we, w_we_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [WORD_W-1:0]   r_wdata, w_wdata_nxt;
    logic                w_active, w_tmo_run, w_accept, w_asm_en, w_word_valid;
    logic [WORD_W-1:0]   w_word;

    assign w_active  = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA) ||
                       (r_state == CHECK);
    assign w_tmo_run = (r_state == LEN1) || (r_state == DATA) || (r_state == CHECK);
    // load_req wins over byte acceptance.
    assign in_ready  = w_active && !load_req;
    assign w_accept  = in_valid && in_ready;
    assign w_asm_en  = w_accept && (r_state == DATA);

    assign w_tmo_inc   = r_tmo + 1'b1;
    assign w_words_inc = r_words + 1'b1;
    assign w_len_full  = {in_data, r_len[7:0]};

    loader_word_assembler u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (load_req),
        .i_en        (w_asm_en),
        .i_byte      (in_data),
        .o_word_valid(w_word_valid),
        .o_word      (w_word)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_csum_nxt     = r_csum;
        w_tmo_nxt      = r_tmo;
        w_words_nxt    = r_words;
        w_err_code_nxt = r_err_code;
        w_we_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        if (load_req) begin
            w_state_nxt    = LEN0;
            w_len_nxt      = '0;
            w_csum_nxt     = '0;
            w_tmo_nxt      = '0;
            w_words_nxt    = '0;
            w_err_code_nxt = ERR_NONE;
        end else if (w_accept) begin
            w_tmo_nxt = '0;
            case (r_state)
                LEN0: begin
                    w_len_nxt[7:0] = in_data;
                    w_state_nxt    = LEN1;
                end
                LEN1: begin
                    w_len_nxt = w_len_full;
                    if (32'(w_len_full) > DEPTH) begin
                        w_state_nxt    = ERROR;
                        w_err_code_nxt = ERR_LEN;
                    end else if (w_len_full == '0) begin
                        w_state_nxt = CHECK;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    w_csum_nxt = r_csum ^ in_data;
                    if (w_word_valid) begin
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = r_words[ADDR_W-1:0];
                        w_wdata_nxt = w_word;
                        w_words_nxt = w_words_inc;
                        if (32'(w_words_inc) == 32'(r_len)) w_state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (in_data == r_csum) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt    = ERROR;
                        w_err_code_nxt = ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end else if (w_tmo_run) begin
            if (32'(w_tmo_inc) == TIMEOUT) begin
                w_state_nxt    = ERROR;
                w_err_code_nxt = ERR_TIMEOUT;
                w_tmo_nxt      = '0;
            end else begin
                w_tmo_nxt = w_tmo_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LEN0;
            r_len      <= '0;
            r_csum     <= '0;
            r_tmo      <= '0;
            r_words    <= '0;
            r_err_code <= ERR_NONE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_csum     <= w_csum_nxt;
            r_tmo      <= w_tmo_nxt;
            r_words    <= w_words_nxt;
            r_err_code <= w_err_code_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign busy         = w_active;
    assign done         = (r_state == DONE);
    assign err          = (r_state == ERROR);
    assign core_rst_n   = (r_state == DONE);
    assign err_code     = r_err_code;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good frame, bad checksum, oversize length,
// timeout boundary, load_req abort, empty frame and asynchronous reset mid-frame.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready, imem_we, core_rst_n, busy, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [1:0]  err_code;
    logic [8:0]  words_loaded;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    imem_boot_loader #(
        .DEPTH  (256),
        .ADDR_W (8),
        .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req    (load_req),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_rst_n  (core_rst_n),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle.
    int unsigned wr_cnt = 0;
    logic [7:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr[wr_cnt[5:0]] <= imem_addr;
            wr_data[wr_cnt[5:0]] <= imem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_list(input logic [7:0] q[$]);
        foreach (q[i]) send(q[i]);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] p[$]);
        logic [7:0] s = 8'h00;
        foreach (p[i]) s ^= p[i];
        return s;
    endfunction

    logic [7:0]  pay[$];
    logic [7:0]  frm[$];
    logic [7:0]  good_cs;
    int unsigned base;

    initial begin
        pay = {8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        good_cs = xsum(pay);

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 1);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_we_addr_wdata", {imem_we, imem_addr, imem_wdata}, 0);
        chk("rst_done_err_code", {done, err, err_code}, 0);
        chk("rst_words", words_loaded, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good 2-word frame, back-to-back
        base = wr_cnt;
        frm = {8'h02, 8'h00};
        foreach (pay[i]) frm.push_back(pay[i]);
        frm.push_back(good_cs);
        send_list(frm);
        chk("f1_done", {done, core_rst_n, err, busy}, 4'b1100);
        chk("f1_words", words_loaded, 2);
        chk("f1_in_ready", in_ready, 0);
        chk("f1_wr_cnt", wr_cnt - base, 2);
        chk("f1_wr0", {wr_addr[base[5:0]], wr_data[base[5:0]]}, {8'd0, 32'h0010_0513});
        chk("f1_wr1", {wr_addr[base[5:0]+1], wr_data[base[5:0]+1]}, {8'd1, 32'h0020_0593});
        idle(3);
        chk("f1_done_holds", {done, core_rst_n}, 2'b11);

        // Same frame with a wrong checksum
        pulse_load();
        chk("ld_clears", {busy, done, core_rst_n, err}, 4'b1000);
        chk("ld_words", words_loaded, 0);
        frm[frm.size()-1] = good_cs ^ 8'h81;
        send_list(frm);
        chk("f2_err", {err, done, core_rst_n}, 3'b100);
        chk("f2_code", err_code, 2);

        // Oversize length
        pulse_load();
        chk("ld_err_clr", {err, err_code}, 0);
        base = wr_cnt;
        send_list({8'h01, 8'h01});
        chk("f3_err", {err, busy}, 2'b10);
        chk("f3_code", err_code, 1);
        idle(2);
        chk("f3_no_write", wr_cnt - base, 0);

        // Timeout: 15 idle cycles tolerated, 16th expires
        pulse_load();
        base = wr_cnt;
        send_list({8'h02, 8'h00, 8'h13, 8'h05});
        idle(15);
        chk("f4_15_ok", {err, busy}, 2'b01);
        send_list({8'h10, 8'h00, 8'h93, 8'h05});
        idle(15);
        chk("f4_15_again_ok", {err, busy}, 2'b01);
        idle(1);
        chk("f4_16_err", {err, core_rst_n}, 2'b10);
        chk("f4_code", err_code, 3);
        chk("f4_one_word", wr_cnt - base, 1);

        // load_req mid-word: partial word dropped, byte during load_req refused
        pulse_load();
        base = wr_cnt;
        send({8'h02});
        send({8'h00});
        send({8'h13});
        send({8'h05});
        in_data  = 8'h10;
        in_valid = 1'b1;
        load_req = 1'b1;
        #1;
        chk("f5_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        load_req = 1'b0;
        in_valid = 1'b0;
        chk("f5_back_to_len0", {busy, words_loaded}, {1'b1, 9'd0});
        send_list({8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, xsum({8'hEF, 8'hBE, 8'hAD, 8'hDE})});
        chk("f5_done", {done, core_rst_n}, 2'b11);
        chk("f5_wr_cnt", wr_cnt - base, 1);
        chk("f5_wr0", {wr_addr[base[5:0]], wr_data[base[5:0]]}, {8'd0, 32'hDEAD_BEEF});

        // Empty frame goes straight to checksum of zero
        pulse_load();
        send_list({8'h00, 8'h00, 8'h00});
        chk("f6_empty_done", {done, words_loaded}, {1'b1, 9'd0});

        // Asynchronous reset in the middle of DATA
        pulse_load();
        send_list({8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93});
        #2;
        rst_n = 1'b0;
        #1;
        chk("f7_rst_flags", {in_ready, busy, core_rst_n, done, err}, 5'b11000);
        chk("f7_rst_we_addr_wdata", {imem_we, imem_addr, imem_wdata}, 0);
        chk("f7_rst_code_words", {err_code, words_loaded}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = wr_cnt;
        send_list(frm[0:frm.size()-2]);
        send_list({good_cs});
        chk("f7_done", {done, core_rst_n, words_loaded}, {2'b11, 9'd2});
        chk("f7_wr_cnt", wr_cnt - base, 2);
        chk("f7_wr1", {wr_addr[base[5:0]+1], wr_data[base[5:0]+1]}, {8'd1, 32'h0020_0593});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
